// File: rtl/rtc_reg_bank_if.sv
// Bus bundle for the RTC register bank: select/edit inputs, timer control, and read-back outputs.
interface rtc_reg_bank_if #(
  parameter int unsigned NUM_REGS = 10,
  parameter int unsigned WIDTH    = 8
);
  logic [NUM_REGS-1:0]       sel;
  logic [NUM_REGS-1:0]       hold;
  logic [NUM_REGS*WIDTH-1:0] rtc_data;
  logic [NUM_REGS*WIDTH-1:0] count_data;
  logic                      cfg_mode;
  logic                      alarm_clear;
  logic [NUM_REGS*WIDTH-1:0] out_data;
  logic                      timer_zero;
  logic                      alarm;
  logic [1:0]                alarm_state;

  modport master (
    output sel, hold, rtc_data, count_data, cfg_mode, alarm_clear,
    input  out_data, timer_zero, alarm, alarm_state
  );

  modport slave (
    input  sel, hold, rtc_data, count_data, cfg_mode, alarm_clear,
    output out_data, timer_zero, alarm, alarm_state
  );
endinterface

// File: rtl/rtc_reg_bank.sv
// RTC time/date/timer register bank with a countdown-alarm FSM and self-clearing alarm timeout.
module rtc_reg_bank #(
  parameter int unsigned NUM_REGS      = 10,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned TIMER_BASE    = 7,
  parameter int unsigned NUM_TIMER     = 3,
  parameter logic [15:0] ALARM_TIMEOUT = 16'd50000
) (
  input logic           clk,
  input logic           reset,
  rtc_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StConf  = 2'b01,
    StRun   = 2'b10,
    StAlarm = 2'b11
  } state_e;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  state_e                         state_q, state_d;
  logic [15:0]                    tmo_cnt_q, tmo_cnt_d;
  logic                           alarm_q, alarm_d;
  logic                           timer_zero;
  logic                           timeout;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (bus.sel[i]) begin
        regs_d[i] = bus.hold[i] ? bus.count_data[i*WIDTH +: WIDTH]
                                : bus.rtc_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // An empty timer range leaves the loop untouched, so timer_zero stays 1.
  always_comb begin
    timer_zero = 1'b1;
    for (int t = 0; t < int'(NUM_TIMER); t++) begin
      if (regs_q[TIMER_BASE + t] != '0) begin
        timer_zero = 1'b0;
      end
    end
  end

  assign timeout = (ALARM_TIMEOUT != 16'd0) && (tmo_cnt_q == ALARM_TIMEOUT - 16'd1);

  // Counter idles at zero outside ALARM, which clears it on every entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StAlarm) begin
      tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tmo_cnt_q <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      alarm_q   <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_mode) state_d = StConf;
      end
      StConf: begin
        if (!bus.cfg_mode) state_d = timer_zero ? StIdle : StRun;
      end
      StRun: begin
        if (timer_zero)        state_d = StAlarm;
        else if (bus.cfg_mode) state_d = StConf;
      end
      StAlarm: begin
        if (bus.alarm_clear || timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered from the next state so alarm tracks state_q == StAlarm exactly.
  always_comb begin
    alarm_d = (state_d == StAlarm);
  end

  assign bus.out_data    = regs_q;
  assign bus.timer_zero  = timer_zero;
  assign bus.alarm       = alarm_q;
  assign bus.alarm_state = state_q;

endmodule

// File: tb/tb_rtc_reg_bank.sv
// Directed bench for rtc_reg_bank: vector table for register loads, hand sequences for the FSM.
module tb_rtc_reg_bank;
  localparam int unsigned NR = 10;
  localparam int unsigned W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_reg_bank_if #(.NUM_REGS(NR), .WIDTH(W)) bus ();

  rtc_reg_bank #(
    .NUM_REGS     (NR),
    .WIDTH        (W),
    .TIMER_BASE   (7),
    .NUM_TIMER    (3),
    .ALARM_TIMEOUT(16'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         idx;
    bit         hold;
    logic [7:0] rtc;
    logic [7:0] cnt;
    logic [7:0] exp;
    bit         exp_tz;
  } vec_t;

  vec_t       vecs[10];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] model[NR];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*W-1:0] model_flat();
    logic [NR*W-1:0] f;
    for (int i = 0; i < int'(NR); i++) f[i*W +: W] = model[i];
    return f;
  endfunction

  // Drives the unselected source with the complement so a swapped mux shows up.
  task automatic load(input int idx, input bit hd, input logic [W-1:0] val);
    bus.sel                    = '0;
    bus.hold                   = '0;
    bus.sel[idx]               = 1'b1;
    bus.hold[idx]              = hd;
    bus.rtc_data[idx*W +: W]   = hd ? ~val : val;
    bus.count_data[idx*W +: W] = hd ? val : ~val;
    tick();
    bus.sel    = '0;
    bus.hold   = '0;
    model[idx] = val;
  endtask

  task automatic enter_alarm();
    load(8, 1'b0, 8'h05);
    bus.cfg_mode = 1'b1;
    tick();
    bus.cfg_mode = 1'b0;
    tick();
    load(8, 1'b0, 8'h00);
    tick();
  endtask

  initial begin
    vecs[0] = '{0,  1'b0, 8'h59, 8'h11, 8'h59, 1'b1};
    vecs[1] = '{-1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[2] = '{8,  1'b1, 8'h33, 8'h02, 8'h02, 1'b0};
    vecs[3] = '{3,  1'b1, 8'h44, 8'h12, 8'h12, 1'b0};
    vecs[4] = '{3,  1'b0, 8'h23, 8'h99, 8'h23, 1'b0};
    vecs[5] = '{8,  1'b0, 8'h00, 8'h55, 8'h00, 1'b1};
    vecs[6] = '{9,  1'b1, 8'h77, 8'h30, 8'h30, 1'b0};
    vecs[7] = '{9,  1'b0, 8'h00, 8'h30, 8'h00, 1'b1};
    vecs[8] = '{7,  1'b1, 8'hAA, 8'h01, 8'h01, 1'b0};
    vecs[9] = '{7,  1'b1, 8'hAA, 8'h00, 8'h00, 1'b1};

    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    reset           = 1'b1;
    bus.sel         = '0;
    bus.hold        = '0;
    bus.rtc_data    = {NR{8'hA5}};
    bus.count_data  = {NR{8'h5A}};
    bus.cfg_mode    = 1'b0;
    bus.alarm_clear = 1'b0;

    #12;
    check("rst_out_data", bus.out_data, '0);
    check("rst_alarm", bus.alarm, 1'b0);
    check("rst_state", bus.alarm_state, 2'b00);
    check("rst_timer_zero", bus.timer_zero, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_out_data", bus.out_data, '0);

    // Register load/edit table
    for (int v = 0; v < 10; v++) begin
      bus.rtc_data   = {NR{8'hA5}};
      bus.count_data = {NR{8'h5A}};
      bus.sel        = '0;
      bus.hold       = '0;
      if (vecs[v].idx >= 0) begin
        bus.sel[vecs[v].idx]                 = 1'b1;
        bus.hold[vecs[v].idx]                = vecs[v].hold;
        bus.rtc_data[vecs[v].idx*W +: W]     = vecs[v].rtc;
        bus.count_data[vecs[v].idx*W +: W]   = vecs[v].cnt;
      end
      #1;
      check($sformatf("vec%0d_no_comb_path", v), bus.out_data, model_flat());
      tick();
      bus.sel  = '0;
      bus.hold = '0;
      if (vecs[v].idx >= 0) begin
        model[vecs[v].idx] = vecs[v].exp;
        check($sformatf("vec%0d_slice", v), bus.out_data[vecs[v].idx*W +: W], vecs[v].exp);
      end
      check($sformatf("vec%0d_out_data", v), bus.out_data, model_flat());
      check($sformatf("vec%0d_timer_zero", v), bus.timer_zero, vecs[v].exp_tz);
      check($sformatf("vec%0d_state", v), bus.alarm_state, 2'b00);
    end
    tick();
    check("hold_after_deselect", bus.out_data, model_flat());

    // Timer flow with abort and timer_zero priority
    load(8, 1'b0, 8'h02);
    check("flow_tz_armed", bus.timer_zero, 1'b0);
    bus.cfg_mode = 1'b1;
    tick();
    check("flow_conf", bus.alarm_state, 2'b01);
    bus.cfg_mode = 1'b0;
    tick();
    check("flow_run", bus.alarm_state, 2'b10);
    check("flow_run_alarm", bus.alarm, 1'b0);
    bus.cfg_mode = 1'b1;
    tick();
    check("flow_abort_conf", bus.alarm_state, 2'b01);
    bus.cfg_mode = 1'b0;
    tick();
    check("flow_rerun", bus.alarm_state, 2'b10);
    load(8, 1'b1, 8'h00);
    check("flow_run_tz", bus.alarm_state, 2'b10);
    check("flow_tz_now", bus.timer_zero, 1'b1);
    bus.cfg_mode = 1'b1;
    tick();
    check("flow_alarm_priority", bus.alarm_state, 2'b11);
    check("flow_alarm_out", bus.alarm, 1'b1);
    tick();
    check("flow_alarm_ignores_cfg", bus.alarm_state, 2'b11);
    bus.cfg_mode    = 1'b0;
    bus.alarm_clear = 1'b1;
    tick();
    bus.alarm_clear = 1'b0;
    check("flow_clear_idle", bus.alarm_state, 2'b00);
    check("flow_clear_alarm", bus.alarm, 1'b0);

    // Empty timer never arms; stray alarm_clear has no effect
    bus.cfg_mode    = 1'b1;
    bus.alarm_clear = 1'b1;
    tick();
    bus.alarm_clear = 1'b0;
    check("empty_conf", bus.alarm_state, 2'b01);
    bus.cfg_mode = 1'b0;
    tick();
    check("empty_idle", bus.alarm_state, 2'b00);
    check("empty_alarm", bus.alarm, 1'b0);

    // Timeout after exactly four ALARM cycles
    enter_alarm();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("tmo_cycle%0d_state", c), bus.alarm_state, 2'b11);
      check($sformatf("tmo_cycle%0d_alarm", c), bus.alarm, 1'b1);
      tick();
    end
    check("tmo_idle", bus.alarm_state, 2'b00);
    check("tmo_alarm_low", bus.alarm, 1'b0);
    tick();
    check("tmo_stays_idle", bus.alarm_state, 2'b00);

    // Clear coinciding with timeout
    enter_alarm();
    tick();
    tick();
    tick();
    check("both_cycle4", bus.alarm_state, 2'b11);
    bus.alarm_clear = 1'b1;
    tick();
    check("both_idle", bus.alarm_state, 2'b00);
    tick();
    bus.alarm_clear = 1'b0;
    check("both_single_return", bus.alarm_state, 2'b00);
    check("both_alarm_low", bus.alarm, 1'b0);

    // Asynchronous reset while in ALARM
    enter_alarm();
    check("rstalarm_state", bus.alarm_state, 2'b11);
    check("rstalarm_data", bus.out_data, model_flat());
    #2;
    reset = 1'b1;
    #1;
    check("rstalarm_alarm", bus.alarm, 1'b0);
    check("rstalarm_out_data", bus.out_data, '0);
    check("rstalarm_fsm", bus.alarm_state, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    bus.cfg_mode = 1'b1;
    tick();
    check("rstalarm_resume_conf", bus.alarm_state, 2'b01);
    bus.cfg_mode = 1'b0;
    tick();
    check("rstalarm_resume_idle", bus.alarm_state, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_reg_bank.md
RTC_REG_BANK -- requirements
Module: rtc_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 10, number of 8-bit-class time/date/timer registers.
REQ-002 Parameter WIDTH, default 8, bits per register (BCD byte).
REQ-003 Parameter TIMER_BASE, default 7, index of first timer register.
REQ-004 Parameter NUM_TIMER, default 3, count of timer registers: TIMER_BASE..TIMER_BASE+NUM_TIMER-1.
REQ-005 Parameter ALARM_TIMEOUT, default 16'd50000, cycles before an unacknowledged alarm self-clears; 0 disables the timeout.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 sel  in  NUM_REGS  per-register chip select.
REQ-009 hold  in  NUM_REGS  per-register edit hold (user-edit source select).
REQ-010 rtc_data  in  NUM_REGS*WIDTH  flattened RTC read data; register i at [i*WIDTH +: WIDTH].
REQ-011 count_data  in  NUM_REGS*WIDTH  flattened user-edit counter data, same packing.
REQ-012 cfg_mode  in  1  timer configuration switch (level).
REQ-013 alarm_clear  in  1  user alarm acknowledge (single-cycle pulse or level).
REQ-014 out_data  out  NUM_REGS*WIDTH  registered contents, same packing.
REQ-015 timer_zero  out  1  high when every timer register equals 0.
REQ-016 alarm  out  1  registered alarm indication.
REQ-017 alarm_state  out  2  current FSM state encoding.

Function
REQ-018 Register i SHALL load count_data slice when sel[i]=1 and hold[i]=1, load rtc_data slice when sel[i]=1 and hold[i]=0, and otherwise retain its value.
REQ-019 Register updates SHALL be visible on out_data one cycle after the qualifying edge; there is no combinational path from inputs to out_data.
REQ-020 timer_zero SHALL be a combinational AND-reduction of (timer register == 0) over the NUM_TIMER timer registers.
REQ-021 The FSM SHALL have states IDLE=2'b00, CONF=2'b01, RUN=2'b10, ALARM=2'b11, which alarm_state reflects directly.
REQ-022 IDLE: go to CONF when cfg_mode=1; otherwise stay.
REQ-023 CONF: when cfg_mode=0, go to RUN if timer_zero=0, or back to IDLE if timer_zero=1 (empty timer never arms); otherwise stay.
REQ-024 RUN: go to ALARM when timer_zero=1; go to CONF when cfg_mode=1 (abort/reconfigure); timer_zero takes priority when both are true.
REQ-025 ALARM: go to IDLE when alarm_clear=1 or the timeout counter reaches ALARM_TIMEOUT-1; cfg_mode is ignored in ALARM.
REQ-026 The timeout counter (16 bits) SHALL be cleared on every entry to ALARM, increment each cycle in ALARM, and saturate rather than wrap.
REQ-027 alarm SHALL be a registered output, 1 exactly in cycles where the state register holds ALARM.
REQ-028 When alarm_clear and timeout occur in the same cycle, the FSM SHALL go to IDLE once; no extra state is entered.
REQ-029 alarm_clear asserted outside ALARM SHALL have no effect.
REQ-030 Widths SHALL scale with parameters; NUM_TIMER=0 SHALL force timer_zero=1.

Reset
REQ-031 On reset all registers SHALL go to 0, out_data=0, FSM=IDLE, alarm=0, alarm_state=2'b00, timeout counter=0, asynchronously and independent of clk.
REQ-032 Reset asserted in any state, including mid-RUN or in ALARM, SHALL abort to the reset values; after deassertion the FSM resumes from IDLE.

Verification
REQ-033 Load: sel[0]=1, hold[0]=0, rtc_data[7:0]=8'h59 for one cycle -> out_data[7:0]=8'h59 on the next cycle; with sel[0]=0 afterwards the value is held.
REQ-034 Edit: sel[8]=1, hold[8]=1, count_data slice 8=8'h02 -> register 8 = 8'h02; other registers unchanged.
REQ-035 Timer flow: cfg_mode 1 then 0 with timer registers {00,02,00} -> RUN; drive timer registers to 0 -> ALARM next cycle and alarm=1; alarm_clear pulse -> IDLE and alarm=0.
REQ-036 Empty timer: cfg_mode 1 then 0 with all timer registers 0 -> IDLE directly; alarm stays 0.
REQ-037 Timeout: ALARM_TIMEOUT=4, enter ALARM with no clear -> IDLE after exactly 4 cycles in ALARM; alarm_clear asserted on the 4th cycle -> single return to IDLE.
REQ-038 Reset in ALARM: assert reset between clock edges -> alarm=0 and all out_data=0 immediately, before the next edge.
